// File: rtl/instr_pkg.sv
// Shared types and bus widths for the instrumented Wishbone initiator.
package instr_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_WAIT_ACK = 2'd2
    } instr_wb_master_state_t;

endpackage

// File: rtl/instr_wb_master.sv
// Single-outstanding Wishbone B4 pipelined initiator driven by a valid/ready request port.
// Latency: stb issued the cycle after accept; rsp_valid_o the cycle after ack (or timeout).
// Backpressure: req_ready_o low while a transaction is open; stb held while wb_stall_i is high.
module instr_wb_master
    import instr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    output logic                wb_we_o,
    output logic [WB_SEL_W-1:0] wb_sel_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    output logic                wb_cyc_o,
    input  logic                wb_stall_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [WB_ADR_W-1:0] req_adr_i,
    input  logic [WB_DAT_W-1:0] req_dat_i,
    input  logic [WB_SEL_W-1:0] req_sel_i,
    output logic                rsp_valid_o,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic [31:0]         txn_count_o
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = '1;

    instr_wb_master_state_t r_state;
    logic [CW-1:0]          r_cnt;
    logic [WB_ADR_W-1:0]    r_adr;
    logic [WB_DAT_W-1:0]    r_dat;
    logic                   r_we;
    logic [WB_SEL_W-1:0]    r_sel;
    logic                   r_stb;
    logic                   r_cyc;
    logic                   r_rsp_vld;
    logic [WB_DAT_W-1:0]    r_rsp_dat;
    logic                   r_rsp_err;
    logic [31:0]            r_txn_cnt;

    logic [CW-1:0]          w_cnt_next;
    logic                   w_timeout;
    logic                   w_ack_ok;

    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next >= TO_LIM);
    // An ack only counts once the strobe has been (or is being) accepted.
    assign w_ack_ok   = wb_ack_i &&
                        ((r_state == ST_WAIT_ACK) || ((r_state == ST_REQUEST) && !wb_stall_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_stb     <= 1'b0;
            r_cyc     <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_txn_cnt <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_adr   <= req_adr_i;
                        r_dat   <= req_dat_i;
                        r_we    <= req_we_i;
                        r_sel   <= req_sel_i;
                        r_stb   <= 1'b1;
                        r_cyc   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_REQUEST;
                    end
                end
                ST_REQUEST, ST_WAIT_ACK: begin
                    r_cnt <= w_cnt_next;
                    if (w_ack_ok) begin
                        r_stb     <= 1'b0;
                        r_cyc     <= 1'b0;
                        r_rsp_vld <= 1'b1;
                        r_rsp_err <= 1'b0;
                        r_rsp_dat <= wb_dat_i;
                        r_txn_cnt <= r_txn_cnt + 32'd1;
                        r_state   <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_stb     <= 1'b0;
                        r_cyc     <= 1'b0;
                        r_rsp_vld <= 1'b1;
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if ((r_state == ST_REQUEST) && !wb_stall_i) begin
                        r_stb   <= 1'b0;
                        r_state <= ST_WAIT_ACK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_we_o     = r_we;
    assign wb_sel_o    = r_sel;
    assign wb_stb_o    = r_stb;
    assign wb_cyc_o    = r_cyc;
    assign rsp_valid_o = r_rsp_vld;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign txn_count_o = r_txn_cnt;

endmodule

// File: tb/tb_instr_wb_master.sv
// Randomized bench for instr_wb_master: a scripted slave per transaction and a
// transaction-level model predicting the completion cycle, status and counters.
module tb_instr_wb_master;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_ack_i, wb_cyc_o, wb_stall_i;
    logic [3:0]  wb_sel_o;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_adr_i, req_dat_i;
    logic [3:0]  req_sel_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_dat_o, txn_count_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_cnt;
    logic [31:0] exp_dat;

    instr_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .txn_count_o(txn_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            wb_ack_i    = 1'($urandom_range(0, 1));
            wb_stall_i  = 1'($urandom_range(0, 1));
            wb_dat_i    = $urandom;
            @(posedge clk_i); #1;
            chk_eq("idle_rsp_vld", {31'd0, rsp_valid_o}, 32'd0);
            chk_eq("idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
            chk_eq("idle_ready", {31'd0, req_ready_o}, 32'd1);
            chk_eq("idle_cnt", txn_count_o, exp_cnt);
            chk_eq("idle_rsp_dat", rsp_dat_o, exp_dat);
        end
    endtask

    // s = stall edges before acceptance, d = edges from acceptance to ack (0 = same edge).
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int s, input int d, input bit noack);
        int          e;
        bit          acked;
        logic [31:0] ackdat;
        acked  = !noack && (s + 1 + d <= TO);
        e      = acked ? (s + 1 + d) : TO;
        ackdat = 32'd0;

        @(negedge clk_i);
        chk_eq("pre_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_adr_i   = adr;
        req_dat_i   = dat;
        req_sel_i   = sel;
        wb_ack_i    = 1'($urandom_range(0, 1));
        wb_stall_i  = 1'($urandom_range(0, 1));
        wb_dat_i    = $urandom;
        @(posedge clk_i); #1;
        chk_eq("acc_cyc", {31'd0, wb_cyc_o}, 32'd1);
        chk_eq("acc_stb", {31'd0, wb_stb_o}, 32'd1);
        chk_eq("acc_ready", {31'd0, req_ready_o}, 32'd0);
        chk_eq("acc_rsp_vld", {31'd0, rsp_valid_o}, 32'd0);

        for (int k = 1; k <= e; k++) begin
            @(negedge clk_i);
            req_valid_i = 1'b1;
            req_we_i    = 1'($urandom_range(0, 1));
            req_adr_i   = $urandom;
            req_dat_i   = $urandom;
            req_sel_i   = 4'($urandom_range(0, 15));
            wb_stall_i  = (k <= s);
            wb_ack_i    = (k <= s) ? 1'($urandom_range(0, 1)) : (acked && (k == s + 1 + d));
            wb_dat_i    = $urandom;
            if (wb_ack_i && !wb_stall_i) ackdat = wb_dat_i;
            @(posedge clk_i); #1;
            if (k < e) begin
                chk_eq("bus_cyc", {31'd0, wb_cyc_o}, 32'd1);
                chk_eq("bus_stb", {31'd0, wb_stb_o}, {31'd0, k <= s});
                chk_eq("bus_adr", wb_adr_o, adr);
                chk_eq("bus_dat", wb_dat_o, dat);
                chk_eq("bus_we_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, we, sel});
                chk_eq("bus_rsp_vld", {31'd0, rsp_valid_o}, 32'd0);
                chk_eq("bus_ready", {31'd0, req_ready_o}, 32'd0);
            end else begin
                if (acked) begin
                    exp_cnt = exp_cnt + 32'd1;
                    exp_dat = ackdat;
                end
                chk_eq("rsp_vld", {31'd0, rsp_valid_o}, 32'd1);
                chk_eq("rsp_err", {31'd0, rsp_err_o}, {31'd0, !acked});
                chk_eq("rsp_dat", rsp_dat_o, exp_dat);
                chk_eq("rsp_cnt", txn_count_o, exp_cnt);
                chk_eq("rsp_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
                chk_eq("rsp_ready", {31'd0, req_ready_o}, 32'd1);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0;
        req_dat_i = '0; req_sel_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
        exp_cnt = 32'd0; exp_dat = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_eq("rst_outs", {wb_adr_o | wb_dat_o | rsp_dat_o | txn_count_o},  32'd0);
        chk_eq("rst_ctl", {26'd0, wb_we_o, wb_stb_o, wb_cyc_o, rsp_valid_o, rsp_err_o, req_ready_o}, 32'd1);
        chk_eq("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        idle_cycles(2);

        // zero-wait read, stalled write, no-ack timeout, ack-on-accept
        txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1, 1'b0);
        chk_eq("t1_dat", rsp_dat_o, exp_dat);
        idle_cycles(1);
        txn(1'b1, 32'h20, 32'h12345678, 4'b0011, 3, 1, 1'b0);
        idle_cycles(2);
        txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 1'b1);
        idle_cycles(1);
        txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 1'b0);
        idle_cycles(1);
        // ack on the timeout edge wins; one edge later it times out
        txn(1'b0, 32'h48, 32'h0, 4'hF, 3, 4, 1'b0);
        txn(1'b0, 32'h4C, 32'h0, 4'hF, 3, 5, 1'b0);
        idle_cycles(1);
        // back-to-back burst of four
        for (int i = 0; i < 4; i++)
            txn(1'(i & 1), 32'h200 + 32'(i * 4), $urandom, 4'hF, i % 2, i % 3, 1'b0);
        idle_cycles(1);

        for (int i = 0; i < 60; i++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        // reset while waiting for ack
        @(negedge clk_i);
        req_valid_i = 1'b1; req_adr_i = 32'h300; req_we_i = 1'b0; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk_i);
        chk_eq("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        exp_cnt = 32'd0; exp_dat = 32'd0;
        chk_eq("mrst_ctl", {28'd0, wb_cyc_o, wb_stb_o, rsp_valid_o, req_ready_o}, 32'd1);
        chk_eq("mrst_cnt", txn_count_o, 32'd0);
        @(negedge clk_i); rst_i = 1'b0; wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk_eq("post_rst_vld", {31'd0, rsp_valid_o}, 32'd0);
            chk_eq("post_rst_cnt", txn_count_o, 32'd0);
        end
        wb_ack_i = 1'b0;
        txn(1'b0, 32'h400, 32'h0, 4'hF, 1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
